// File: rtl/mips_dmem_responder.sv
// Data-memory responder for the MIPS core: word RAM, pass/fail store checker and a
// write-log FIFO with a valid/ready drain port.
module mips_dmem_responder #(
  parameter int unsigned MEM_WORDS    = 64,
  parameter int unsigned PASS_ADDR    = 84,
  parameter int unsigned PASS_DATA    = 7,
  parameter int unsigned SCRATCH_ADDR = 80,
  parameter int unsigned LOG_DEPTH    = 8
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        memwrite,
  input  logic [31:0] dataadr,
  input  logic [31:0] writedata,
  output logic [31:0] readdata,
  output logic        done,
  output logic        pass,
  output logic        log_valid,
  input  logic        log_ready,
  output logic [31:0] log_addr,
  output logic [31:0] log_data,
  output logic [7:0]  drop_count,
  output logic [15:0] write_count
);

  localparam int unsigned AW = $clog2(MEM_WORDS);
  localparam int unsigned LW = $clog2(LOG_DEPTH);
  localparam logic [31:0] MemBytes = 32'(MEM_WORDS * 4);
  localparam logic [LW:0] LogFull  = (LW + 1)'(LOG_DEPTH);

  typedef enum logic [1:0] {StRun, StPass, StFail} state_e;

  // ---------------------------------------------------------------------------
  // Data RAM
  // ---------------------------------------------------------------------------
  logic [31:0]   mem [MEM_WORDS];
  logic [AW-1:0] idx;
  logic          addr_ok;

  assign idx     = dataadr[AW+1:2];
  assign addr_ok = (dataadr[1:0] == 2'b00) && (dataadr < MemBytes);

  // RAM keeps its contents across reset, so it has no reset branch.
  always_ff @(posedge clk) begin
    if (memwrite && addr_ok) begin
      mem[idx] <= writedata;
    end
  end

  assign readdata = addr_ok ? mem[idx] : '0;

  // ---------------------------------------------------------------------------
  // Checker FSM
  // ---------------------------------------------------------------------------
  state_e state_q, state_d;

  always_comb begin
    state_d = state_q;
    if (state_q == StRun && memwrite) begin
      if (dataadr == 32'(PASS_ADDR)) begin
        state_d = (writedata == 32'(PASS_DATA)) ? StPass : StFail;
      end else if (dataadr != 32'(SCRATCH_ADDR)) begin
        state_d = StFail;
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= StRun;
    end else begin
      state_q <= state_d;
    end
  end

  assign done = (state_q != StRun);
  assign pass = (state_q == StPass);

  // ---------------------------------------------------------------------------
  // Write-log FIFO
  // ---------------------------------------------------------------------------
  logic [31:0]   log_addr_mem [LOG_DEPTH];
  logic [31:0]   log_data_mem [LOG_DEPTH];
  logic [LW-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [LW:0]   count_q, count_d;
  logic [7:0]    drop_q, drop_d;
  logic [15:0]   wcnt_q, wcnt_d;
  logic          full, push, pop;

  assign full      = (count_q == LogFull);
  assign log_valid = (count_q != '0);
  assign pop       = log_valid && log_ready;
  // A pop in the same cycle frees the slot the push needs.
  assign push      = memwrite && (!full || pop);

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    drop_d   = drop_q;
    wcnt_d   = wcnt_q;
    if (push) begin
      wr_ptr_d = wr_ptr_q + LW'(1);
    end
    if (pop) begin
      rd_ptr_d = rd_ptr_q + LW'(1);
    end
    if (push && !pop) begin
      count_d = count_q + (LW + 1)'(1);
    end else if (pop && !push) begin
      count_d = count_q - (LW + 1)'(1);
    end
    if (memwrite && !push && drop_q != 8'hff) begin
      drop_d = drop_q + 8'd1;
    end
    if (memwrite && wcnt_q != 16'hffff) begin
      wcnt_d = wcnt_q + 16'd1;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      drop_q   <= '0;
      wcnt_q   <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      drop_q   <= drop_d;
      wcnt_q   <= wcnt_d;
    end
  end

  always_ff @(posedge clk) begin
    if (push) begin
      log_addr_mem[wr_ptr_q] <= dataadr;
      log_data_mem[wr_ptr_q] <= writedata;
    end
  end

  // Gated by valid so an emptied log reads back as zero.
  assign log_addr    = log_valid ? log_addr_mem[rd_ptr_q] : '0;
  assign log_data    = log_valid ? log_data_mem[rd_ptr_q] : '0;
  assign drop_count  = drop_q;
  assign write_count = wcnt_q;

endmodule

// File: tb/tb_mips_dmem_responder.sv
// Self-checking bench for mips_dmem_responder: directed vector table, hand sequences for
// log corner cases and reset, then randomized stores against a queue-based reference model.
module tb_mips_dmem_responder;

  logic        clk;
  logic        reset;
  logic        memwrite;
  logic [31:0] dataadr;
  logic [31:0] writedata;
  logic [31:0] readdata;
  logic        done;
  logic        pass;
  logic        log_valid;
  logic        log_ready;
  logic [31:0] log_addr;
  logic [31:0] log_data;
  logic [7:0]  drop_count;
  logic [15:0] write_count;

  mips_dmem_responder dut (
    .clk        (clk),
    .reset      (reset),
    .memwrite   (memwrite),
    .dataadr    (dataadr),
    .writedata  (writedata),
    .readdata   (readdata),
    .done       (done),
    .pass       (pass),
    .log_valid  (log_valid),
    .log_ready  (log_ready),
    .log_addr   (log_addr),
    .log_data   (log_data),
    .drop_count (drop_count),
    .write_count(write_count)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  int nerr = 0;
  int nchk = 0;

  // Reference model: 0 = running, 1 = passed, 2 = failed.
  typedef struct {
    logic [31:0] a;
    logic [31:0] d;
  } ent_t;

  ent_t        q[$];
  logic [31:0] mmem[64];
  bit          known[64];
  int          m_state;
  int          m_drop;
  int          m_wc;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    nchk++;
    if (act !== exp) begin
      nerr++;
      $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    q.delete();
    m_state = 0;
    m_drop  = 0;
    m_wc    = 0;
  endtask

  task automatic model_step(input bit we, input logic [31:0] adr, input logic [31:0] wd,
                            input bit rdy);
    if (q.size() > 0 && rdy) void'(q.pop_front());
    if (we) begin
      if (m_wc < 65535) m_wc++;
      if (q.size() < 8) q.push_back('{a: adr, d: wd});
      else if (m_drop < 255) m_drop++;
      if (m_state == 0) begin
        if (adr == 84) m_state = (wd == 7) ? 1 : 2;
        else if (adr != 80) m_state = 2;
      end
      if (adr[1:0] == 2'b00 && adr < 256) begin
        mmem[adr[7:2]]  = wd;
        known[adr[7:2]] = 1'b1;
      end
    end
  endtask

  // Drive one cycle; returns #1 after the rising edge.
  task automatic step(input bit we, input logic [31:0] adr, input logic [31:0] wd, input bit rdy);
    memwrite  = we;
    dataadr   = adr;
    writedata = wd;
    log_ready = rdy;
    model_step(we, adr, wd, rdy);
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    reset = 1'b0;
    #2;
    reset = 1'b1;
    model_reset();
  endtask

  task automatic check_all();
    logic [31:0] adr;
    adr = dataadr;
    chk("done", {31'b0, done}, (m_state != 0) ? 32'd1 : 32'd0);
    chk("pass", {31'b0, pass}, (m_state == 1) ? 32'd1 : 32'd0);
    chk("log_valid", {31'b0, log_valid}, (q.size() > 0) ? 32'd1 : 32'd0);
    if (q.size() > 0) begin
      chk("log_addr", log_addr, q[0].a);
      chk("log_data", log_data, q[0].d);
    end
    chk("drop_count", {24'b0, drop_count}, 32'(m_drop));
    chk("write_count", {16'b0, write_count}, 32'(m_wc));
    if (adr[1:0] != 2'b00 || adr >= 256) chk("readdata_oob", readdata, 32'h0);
    else if (known[adr[7:2]]) chk("readdata", readdata, mmem[adr[7:2]]);
  endtask

  typedef struct {
    bit          rst;
    bit          we;
    logic [31:0] adr;
    logic [31:0] wd;
    bit          chk_rd;
    logic [31:0] rd;
    bit          done;
    bit          pass;
  } vec_t;

  vec_t vecs[6];

  initial begin
    reset     = 1'b0;
    memwrite  = 1'b0;
    dataadr   = '0;
    writedata = '0;
    log_ready = 1'b0;
    model_reset();
    #12;
    reset = 1'b1;
    @(posedge clk);
    #1;

    chk("reset_done", {31'b0, done}, 32'd0);
    chk("reset_pass", {31'b0, pass}, 32'd0);
    chk("reset_log_valid", {31'b0, log_valid}, 32'd0);
    chk("reset_log_addr", log_addr, 32'd0);
    chk("reset_write_count", {16'b0, write_count}, 32'd0);

    //          rst we  adr  wd  chk_rd rd  done pass
    vecs[0] = '{1'b1, 1'b1, 80, 5, 1'b1, 5, 1'b0, 1'b0};
    vecs[1] = '{1'b0, 1'b1, 84, 7, 1'b1, 7, 1'b1, 1'b1};
    vecs[2] = '{1'b0, 1'b0, 84, 0, 1'b1, 7, 1'b1, 1'b1};
    vecs[3] = '{1'b1, 1'b1, 84, 3, 1'b1, 3, 1'b1, 1'b0};
    vecs[4] = '{1'b0, 1'b1, 84, 7, 1'b1, 7, 1'b1, 1'b0};
    vecs[5] = '{1'b1, 1'b1, 60, 9, 1'b1, 9, 1'b1, 1'b0};
    for (int i = 0; i < 6; i++) begin
      if (vecs[i].rst) do_reset();
      step(vecs[i].we, vecs[i].adr, vecs[i].wd, 1'b1);
      chk($sformatf("vec%0d_done", i), {31'b0, done}, {31'b0, vecs[i].done});
      chk($sformatf("vec%0d_pass", i), {31'b0, pass}, {31'b0, vecs[i].pass});
      if (vecs[i].chk_rd) chk($sformatf("vec%0d_readdata", i), readdata, vecs[i].rd);
    end
    chk("fail_log_valid", {31'b0, log_valid}, 32'd1);
    chk("fail_log_addr", log_addr, 32'd60);
    chk("fail_log_data", log_data, 32'd9);

    // Overflow: 10 stores with the consumer stalled, then drain in order.
    do_reset();
    for (int i = 0; i < 10; i++) step(1'b1, 80, 32'(i), 1'b0);
    chk("ovf_drop_count", {24'b0, drop_count}, 32'd2);
    chk("ovf_write_count", {16'b0, write_count}, 32'd10);
    for (int i = 0; i < 8; i++) begin
      chk($sformatf("drain%0d_valid", i), {31'b0, log_valid}, 32'd1);
      chk($sformatf("drain%0d_data", i), log_data, 32'(i));
      step(1'b0, 0, 0, 1'b1);
    end
    chk("drain_empty", {31'b0, log_valid}, 32'd0);
    step(1'b0, 0, 0, 1'b1);
    chk("empty_ready_valid", {31'b0, log_valid}, 32'd0);

    // Full log with simultaneous push and pop.
    do_reset();
    for (int i = 0; i < 8; i++) step(1'b1, 80, 32'(10 + i), 1'b0);
    step(1'b1, 80, 100, 1'b1);
    chk("fullpp_drop", {24'b0, drop_count}, 32'd0);
    for (int i = 0; i < 8; i++) begin
      chk($sformatf("fullpp%0d_valid", i), {31'b0, log_valid}, 32'd1);
      chk($sformatf("fullpp%0d_data", i), log_data, (i == 7) ? 32'd100 : 32'(11 + i));
      step(1'b0, 0, 0, 1'b1);
    end
    chk("fullpp_empty", {31'b0, log_valid}, 32'd0);

    // Reset mid-program: state clears, RAM keeps its words.
    do_reset();
    step(1'b1, 0, 32'h11, 1'b0);
    step(1'b1, 4, 32'h22, 1'b0);
    step(1'b1, 8, 32'h33, 1'b0);
    chk("pre_rst_done", {31'b0, done}, 32'd1);
    memwrite = 1'b0;
    dataadr  = 4;
    reset    = 1'b0;
    #2;
    chk("mid_rst_done", {31'b0, done}, 32'd0);
    chk("mid_rst_log_valid", {31'b0, log_valid}, 32'd0);
    chk("mid_rst_log_data", log_data, 32'd0);
    chk("mid_rst_write_count", {16'b0, write_count}, 32'd0);
    chk("mid_rst_readdata", readdata, 32'h22);
    reset = 1'b1;
    model_reset();
    dataadr = 8;
    #1;
    chk("post_rst_readdata", readdata, 32'h33);

    // Randomized traffic against the reference model.
    for (int n = 0; n < 600; n++) begin
      logic [31:0] adr;
      logic [31:0] wd;
      if ($urandom_range(0, 39) == 0) do_reset();
      case ($urandom_range(0, 3))
        0:       adr = 80;
        1:       adr = 84;
        2:       adr = {24'b0, 6'($urandom_range(0, 63)), 2'b00};
        default: adr = $urandom;
      endcase
      wd = ($urandom_range(0, 2) == 0) ? 32'd7 : $urandom;
      step(1'($urandom_range(0, 1)), adr, wd, ($urandom_range(0, 3) == 0));
      check_all();
    end

    $display("Result: errors=%0d of %0d checks", nerr, nchk);
    $finish;
  end

endmodule
